multi_port_reg_file: RTL and testbench

//  Parametrised register file with 2 combinational read ports and 2 write ports.

---
 rtl/multi_port_reg_file.sv | 160 ++++++++++++++++
 tb/tb_multi_port_reg_file.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_reg_file.sv
// Two-read / two-write register file with optional zero register, optional
// write-to-read bypass and a one-entry-per-cycle clear sequencer.
module multi_port_reg_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              regWrite0,
  input  logic [ADDR_W-1:0] writeReg0,
  input  logic [DATA_W-1:0] writeData0,
  input  logic              regWrite1,
  input  logic [ADDR_W-1:0] writeReg1,
  input  logic [DATA_W-1:0] writeData1,
  input  logic              clrReq,
  output logic              clrBusy,
  output logic              clrDone
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic idle_s;
  logic sweep_s;
  logic wr0_ok_s;
  logic wr1_ok_s;
  logic byp0_s;
  logic byp1_s;

  // Read mux: zero register first, then port 1 bypass, port 0 bypass, storage.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              byp1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1,
    input logic              byp0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0
  );
    logic [DATA_W-1:0] r;
    if ((ZERO_R0 != 0) && (addr == {ADDR_W{1'b0}})) begin
      r = {DATA_W{1'b0}};
    end else if (byp1 && (a1 == addr)) begin
      r = d1;
    end else if (byp0 && (a0 == addr)) begin
      r = d0;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  assign idle_s   = (state_q == ST_IDLE);
  assign sweep_s  = (state_q == ST_SWEEP);
  // User writes only land while idle; address 0 is read-only when hard-wired.
  assign wr0_ok_s = idle_s && regWrite0 &&
                    !((ZERO_R0 != 0) && (writeReg0 == {ADDR_W{1'b0}}));
  assign wr1_ok_s = idle_s && regWrite1 &&
                    !((ZERO_R0 != 0) && (writeReg1 == {ADDR_W{1'b0}}));
  assign byp0_s   = (BYPASS != 0) && idle_s && regWrite0;
  assign byp1_s   = (BYPASS != 0) && idle_s && regWrite1;

  // Per-entry next value: sweep clear, else port 1, else port 0, else hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sweep_s && (ptr_q == ADDR_W'(i))) begin
        mem_d[i] = {DATA_W{1'b0}};
      end else if (wr1_ok_s && (writeReg1 == ADDR_W'(i))) begin
        mem_d[i] = writeData1;
      end else if (wr0_ok_s && (writeReg0 == ADDR_W'(i))) begin
        mem_d[i] = writeData0;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Clear sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clrReq) begin
          state_d = ST_SWEEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Sequencer state and pointer registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage array.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    readData1 = read_mux(readReg1, mem_q[readReg1], byp1_s, writeReg1, writeData1,
                         byp0_s, writeReg0, writeData0);
    readData2 = read_mux(readReg2, mem_q[readReg2], byp1_s, writeReg1, writeData1,
                         byp0_s, writeReg0, writeData0);
  end

  assign clrBusy = (state_q == ST_SWEEP);
  assign clrDone = (state_q == ST_DONE);

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Scoreboard bench: three configurations (default, no bypass, zero register)
// share one stimulus stream; expectations are queued and checked per task.
module tb_multi_port_reg_file;

  localparam int DW = 16;
  localparam int AW = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst;
  logic [AW-1:0] rr1, rr2, wa0, wa1;
  logic          we0, we1, clr;
  logic [DW-1:0] wd0, wd1;
  logic [DW-1:0] rd1_a, rd2_a, rd1_n, rd2_n, rd1_z, rd2_z;
  logic          busy_a, done_a, busy_n, done_n, busy_z, done_z;

  multi_port_reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0), .BYPASS(1)) u_dut (
    .clock(clock), .rst(rst), .readReg1(rr1), .readReg2(rr2),
    .readData1(rd1_a), .readData2(rd2_a),
    .regWrite0(we0), .writeReg0(wa0), .writeData0(wd0),
    .regWrite1(we1), .writeReg1(wa1), .writeData1(wd1),
    .clrReq(clr), .clrBusy(busy_a), .clrDone(done_a));

  multi_port_reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0), .BYPASS(0)) u_nb (
    .clock(clock), .rst(rst), .readReg1(rr1), .readReg2(rr2),
    .readData1(rd1_n), .readData2(rd2_n),
    .regWrite0(we0), .writeReg0(wa0), .writeData0(wd0),
    .regWrite1(we1), .writeReg1(wa1), .writeData1(wd1),
    .clrReq(clr), .clrBusy(busy_n), .clrDone(done_n));

  multi_port_reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1), .BYPASS(1)) u_z (
    .clock(clock), .rst(rst), .readReg1(rr1), .readReg2(rr2),
    .readData1(rd1_z), .readData2(rd2_z),
    .regWrite0(we0), .writeReg0(wa0), .writeData0(wd0),
    .regWrite1(we1), .writeReg1(wa1), .writeData1(wd1),
    .clrReq(clr), .clrBusy(busy_z), .clrDone(done_z));

  typedef struct {
    string         tag;
    int            sel;
    logic [DW-1:0] exp;
    logic [DW-1:0] obs;
  } chk_t;

  chk_t sb[$];
  chk_t res[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [DW-1:0] observe(input int sel);
    case (sel)
      0: return rd1_a;
      1: return rd2_a;
      2: return rd1_n;
      3: return rd1_z;
      4: return {{(DW-1){1'b0}}, busy_a};
      5: return {{(DW-1){1'b0}}, done_a};
      6: return rd2_z;
      7: return {{(DW-1){1'b0}}, busy_z};
      default: return {DW{1'bx}};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [DW-1:0] e);
    chk_t c;
    c.tag = tag; c.sel = sel; c.exp = e; c.obs = '0;
    sb.push_back(c);
  endtask

  task automatic sample();
    chk_t c;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      c.obs = observe(c.sel);
      res.push_back(c);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
    sample();
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    chk_t r;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    for (int i = 0; i < 8; i++) begin
      rr1 = AW'(i);
      #1;
      expect_val("reset_rd_a", 0, 16'h0000);
      expect_val("reset_rd_z", 3, 16'h0000);
      sample();
    end
    expect_val("reset_busy", 4, 16'h0000);
    expect_val("reset_done", 5, 16'h0000);
    sample();
    #1 rst = 1'b1;
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  task automatic test_write_read();
    chk_t r;
    step(); we0 = 1'b1; wa0 = 3'd3; wd0 = 16'h1234; rr1 = 3'd0; rr2 = 3'd0;
    step(); idle_inputs(); rr1 = 3'd3;
    expect_val("wr_rd_a", 0, 16'h1234);
    expect_val("wr_rd_nb", 2, 16'h1234);
    expect_val("wr_rd_z", 3, 16'h1234);
    smp();
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  task automatic test_dual_write();
    chk_t r;
    step(); we0 = 1'b1; wa0 = 3'd5; wd0 = 16'hAAAA;
    we1 = 1'b1; wa1 = 3'd5; wd1 = 16'h5555; rr1 = 3'd5; rr2 = 3'd5;
    expect_val("dual_byp_a", 1, 16'h5555);
    expect_val("dual_byp_z", 6, 16'h5555);
    expect_val("dual_nb_old", 2, 16'h0000);
    smp();
    step(); wa0 = 3'd6; wd0 = 16'h0606; wa1 = 3'd7; wd1 = 16'h0707;
    expect_val("dual_same_a", 0, 16'h5555);
    expect_val("dual_same_nb", 2, 16'h5555);
    smp();
    step(); idle_inputs(); rr1 = 3'd6; rr2 = 3'd7;
    expect_val("dual_diff0_a", 0, 16'h0606);
    expect_val("dual_diff1_a", 1, 16'h0707);
    expect_val("dual_diff0_nb", 2, 16'h0606);
    expect_val("dual_diff1_z", 6, 16'h0707);
    smp();
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  task automatic test_bypass();
    chk_t r;
    step(); we0 = 1'b1; wa0 = 3'd2; wd0 = 16'h1111; rr1 = 3'd0; rr2 = 3'd0;
    step(); wd0 = 16'hBEEF; rr1 = 3'd2;
    expect_val("byp_new_a", 0, 16'hBEEF);
    expect_val("byp_old_nb", 2, 16'h1111);
    expect_val("byp_new_z", 3, 16'hBEEF);
    smp();
    step(); wa0 = 3'd4; wd0 = 16'h0A0A; we1 = 1'b1; wa1 = 3'd4; wd1 = 16'h0B0B;
    rr1 = 3'd4; rr2 = 3'd2;
    expect_val("byp_p1_wins", 0, 16'h0B0B);
    expect_val("byp_stored", 1, 16'hBEEF);
    expect_val("byp_nb_unwritten", 2, 16'h0000);
    smp();
    step(); wd0 = 16'h0C0C; wa1 = 3'd1; wd1 = 16'h0D0D; rr2 = 3'd1;
    expect_val("byp_p0_only", 0, 16'h0C0C);
    expect_val("byp_p1_other", 1, 16'h0D0D);
    expect_val("byp_nb_prev", 2, 16'h0B0B);
    smp();
    step(); idle_inputs();
    expect_val("byp_commit4", 0, 16'h0C0C);
    expect_val("byp_commit1", 1, 16'h0D0D);
    smp();
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  task automatic test_zero_r0();
    chk_t r;
    step(); we0 = 1'b1; wa0 = 3'd0; wd0 = 16'hFFFF; rr1 = 3'd0;
    expect_val("zero_same_z", 3, 16'h0000);
    expect_val("zero_same_a", 0, 16'hFFFF);
    expect_val("zero_same_nb", 2, 16'h0000);
    smp();
    step(); we0 = 1'b0; we1 = 1'b1; wa1 = 3'd0; wd1 = 16'hEEEE;
    expect_val("zero_next_z", 3, 16'h0000);
    expect_val("zero_p1_byp_a", 0, 16'hEEEE);
    expect_val("zero_next_nb", 2, 16'hFFFF);
    smp();
    step(); idle_inputs();
    expect_val("zero_after_z", 3, 16'h0000);
    expect_val("zero_after_a", 0, 16'hEEEE);
    smp();
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  task automatic test_clear();
    chk_t r;
    for (int i = 0; i < 4; i++) begin
      step(); we0 = 1'b1; wa0 = AW'(2*i); wd0 = 16'hC000 + 16'(2*i);
      we1 = 1'b1; wa1 = AW'(2*i+1); wd1 = 16'hC000 + 16'(2*i+1);
    end
    step(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      rr1 = AW'(2*i); rr2 = AW'(2*i+1);
      expect_val("fill_even", 0, 16'hC000 + 16'(2*i));
      expect_val("fill_odd", 1, 16'hC000 + 16'(2*i+1));
      smp();
      step();
    end
    clr = 1'b1; we0 = 1'b1; wa0 = 3'd7; wd0 = 16'h7777;
    expect_val("clr_req_busy", 4, 16'h0000);
    smp();
    step(); idle_inputs();
    for (int c = 0; c < 8; c++) begin
      rr1 = 3'd1; rr2 = 3'd7;
      we0 = (c == 3); wa0 = 3'd1; wd0 = 16'hABCD;
      expect_val("sweep_busy", 4, 16'h0001);
      expect_val("sweep_done", 5, 16'h0000);
      expect_val("sweep_busy_z", 7, 16'h0001);
      expect_val("sweep_e7_kept", 1, 16'h7777);
      expect_val("sweep_e1", 0, (c < 2) ? 16'hC001 : 16'h0000);
      smp();
      step();
    end
    idle_inputs();
    expect_val("done_busy", 4, 16'h0000);
    expect_val("done_pulse", 5, 16'h0001);
    expect_val("done_e7", 1, 16'h0000);
    smp();
    step();
    expect_val("after_done", 5, 16'h0000);
    expect_val("after_busy", 4, 16'h0000);
    smp();
    for (int i = 0; i < 4; i++) begin
      step(); rr1 = AW'(2*i); rr2 = AW'(2*i+1);
      expect_val("cleared_even", 0, 16'h0000);
      expect_val("cleared_odd", 1, 16'h0000);
      smp();
    end
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    chk_t r;
    int busy_cnt, done_cnt;
    step(); we0 = 1'b1; wa0 = 3'd5; wd0 = 16'h5A5A; we1 = 1'b1; wa1 = 3'd2; wd1 = 16'hA5A5;
    step(); idle_inputs(); clr = 1'b1;
    step(); clr = 1'b0;
    repeat (4) step();
    rr1 = 3'd5; rr2 = 3'd2;
    #1;
    expect_val("pre_rst_busy", 4, 16'h0001);
    expect_val("pre_rst_e5", 0, 16'h5A5A);
    sample();
    rst = 1'b0;
    #1;
    expect_val("rst_mid_e5", 0, 16'h0000);
    expect_val("rst_mid_e2", 1, 16'h0000);
    expect_val("rst_mid_busy", 4, 16'h0000);
    expect_val("rst_mid_done", 5, 16'h0000);
    sample();
    @(negedge clock);
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done_a) done_cnt++;
    end
    r.tag = "no_done_after_rst"; r.sel = -1; r.exp = 16'd0; r.obs = 16'(done_cnt);
    res.push_back(r);
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
    end
    r.tag = "resweep_busy_cycles"; r.exp = 16'd8; r.obs = 16'(busy_cnt);
    res.push_back(r);
    r.tag = "resweep_done_pulses"; r.exp = 16'd1; r.obs = 16'(done_cnt);
    res.push_back(r);
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    chk_t r;
    logic b, d;
    step(); clr = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      b = (k < 8) || ((k >= 10) && (k < 18));
      d = (k == 8) || (k == 18);
      expect_val("b2b_busy", 4, {15'd0, b});
      expect_val("b2b_done", 5, {15'd0, d});
      smp();
    end
    clr = 1'b0;
    repeat (12) step();
    while (res.size() > 0) begin
      r = res.pop_front(); n_checks++;
      if (r.obs !== r.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%h expected 0x%h", r.tag, r.obs, r.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rr1 = '0; rr2 = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
    test_reset();
    test_write_read();
    test_dual_write();
    test_bypass();
    test_zero_r0();
    test_clear();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
